fabric_link_vc: RTL and testbench

- Parametrised link stage placed between adjacent tiles of a generalised ROWS x COLS fabric, carrying NUM_CH independent channels (request/response virtual channels) over one physical link.
- Per-channel FIFO buffering with real valid/ready backpressure. Round-robin arbitration onto a single output with per-channel downstream ready, so a stalled channel never blocks the others.
- Successor to the tied-high-ready fabric links: backpressure is honoured end to end.

---
 rtl/fabric_link_vc.sv | 131 +++++++++++++
 tb/tb_fabric_link_vc.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fabric_link_vc.sv
// Multi-channel fabric link stage: per-channel FIFOs, round-robin arbitration, per-channel downstream ready.
// Optional per-channel transfer counters enabled by FABRIC_LINK_STATS_EN.
package fabric_link_vc_pkg;
  typedef struct packed {
    logic [3:0] dst_row;
    logic [3:0] dst_col;
    logic [7:0] payload;
  } t_tile_trans;
endpackage

module fabric_link_vc
  import fabric_link_vc_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = $bits(t_tile_trans),
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              in_valid,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  in_data,
  output logic [NUM_CH-1:0]              in_ready,
  output logic                           out_valid,
  output logic [CH_W-1:0]                out_ch,
  output logic [DATA_W-1:0]              out_data,
  input  logic [NUM_CH-1:0]              out_ready,
  output logic                           err_overflow,
  output logic [NUM_CH-1:0][15:0]        stat_xfer_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0]             mem [NUM_CH][DEPTH];
  logic [NUM_CH-1:0][PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [NUM_CH-1:0][CNT_W-1:0]  count;
  logic [CH_W-1:0]               rr_ptr;
  logic [NUM_CH-1:0]             eligible, push, pop;
  logic [CH_W-1:0]               grant, gidx;
  logic                          found;

  // Flow control uses registered counts only, so in_ready never depends on out_ready.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      in_ready[c] = (count[c] != CNT_W'(DEPTH));
      eligible[c] = (count[c] != '0) && out_ready[c];
      push[c]     = in_valid[c] && in_ready[c];
    end
  end

  // Round-robin search upward from rr_ptr; out_ready reaches the outputs combinationally.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      gidx = CH_W'((32'(rr_ptr) + i) % NUM_CH);
      if (!found && eligible[gidx]) begin
        found = 1'b1;
        grant = gidx;
      end
    end
  end

  always_comb begin
    out_valid = found;
    out_ch    = grant;
    out_data  = found ? mem[grant][rd_ptr[grant]] : '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      pop[c] = found && (grant == CH_W'(c));
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!rst && push[c]) begin
        mem[c][wr_ptr[c]] <= in_data[c];
      end
    end
  end

  // Pointer/count bookkeeping; a full channel stays blocked even when popped the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rr_ptr       <= '0;
      err_overflow <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        if (push[c] && !pop[c]) begin
          count[c] <= count[c] + CNT_W'(1);
        end else if (!push[c] && pop[c]) begin
          count[c] <= count[c] - CNT_W'(1);
        end
      end
      if (found) begin
        rr_ptr <= CH_W'((32'(grant) + 32'd1) % NUM_CH);
      end
      if ((in_valid & ~in_ready) != '0) begin
        err_overflow <= 1'b1;
      end
    end
  end

`ifdef FABRIC_LINK_STATS_EN
  logic [NUM_CH-1:0][15:0] stat_q;

  // Saturating per-channel transfer counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (pop[c] && (stat_q[c] != 16'hFFFF)) begin
          stat_q[c] <= stat_q[c] + 16'd1;
        end
      end
    end
  end

  assign stat_xfer_cnt = stat_q;
`else
  assign stat_xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_fabric_link_vc.sv
// Randomized and directed bench for fabric_link_vc against a queue-based reference model.
module tb_fabric_link_vc;
  import fabric_link_vc_pkg::*;

  localparam int NCH = 2;
  localparam int DEP = 4;
  localparam int DW  = $bits(t_tile_trans);

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NCH-1:0]            in_valid;
  logic [NCH-1:0][DW-1:0]    in_data;
  logic [NCH-1:0]            in_ready;
  logic                      out_valid;
  logic [0:0]                out_ch;
  logic [DW-1:0]             out_data;
  logic [NCH-1:0]            out_ready;
  logic                      err_overflow;
  logic [NCH-1:0][15:0]      stat_xfer_cnt;

  fabric_link_vc #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ch       (out_ch),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .err_overflow (err_overflow),
    .stat_xfer_cnt(stat_xfer_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per channel, round-robin start index, sticky error, counters.
  logic [DW-1:0] mq [NCH][$];
  int            m_rr;
  bit            m_err;
  int            m_stat [NCH];
  int            total;
  int            bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare outputs for the currently driven inputs, then advance model across one edge.
  task automatic cycle();
    int g;
    bit v;
    bit full [NCH];
    #1;
    v = 1'b0;
    g = 0;
    for (int i = 0; i < NCH; i++) begin
      int c;
      c = (m_rr + i) % NCH;
      if (!v && mq[c].size() > 0 && out_ready[c]) begin
        v = 1'b1;
        g = c;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      check("in_ready", 32'(in_ready[c]), 32'(mq[c].size() < DEP));
`ifdef FABRIC_LINK_STATS_EN
      check("stat", 32'(stat_xfer_cnt[c]), 32'(m_stat[c]));
`else
      check("stat", 32'(stat_xfer_cnt[c]), 32'd0);
`endif
    end
    check("out_valid", 32'(out_valid), 32'(v));
    if (v) begin
      check("out_ch", 32'(out_ch), 32'(g));
      check("out_data", 32'(out_data), 32'(mq[g][0]));
    end else begin
      check("out_data_idle", 32'(out_data), 32'd0);
    end
    check("err_overflow", 32'(err_overflow), 32'(m_err));
    @(posedge clk);
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        mq[c].delete();
        m_stat[c] = 0;
      end
      m_rr  = 0;
      m_err = 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) full[c] = (mq[c].size() >= DEP);
      if (v) begin
        void'(mq[g].pop_front());
        m_rr = (g + 1) % NCH;
        if (m_stat[g] < 16'hFFFF) m_stat[g]++;
      end
      for (int c = 0; c < NCH; c++) begin
        if (in_valid[c]) begin
          if (full[c]) m_err = 1'b1;
          else         mq[c].push_back(in_data[c]);
        end
      end
    end
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [1:0] ordy, input logic r);
    in_valid   = v;
    in_data[0] = d0;
    in_data[1] = d1;
    out_ready  = ordy;
    rst        = r;
    cycle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = '0;
    for (int c = 0; c < NCH; c++) m_stat[c] = 0;
    m_rr = 0; m_err = 1'b0;
    @(posedge clk);
    #1;
    drive(2'b00, 0, 0, 2'b11, 1'b1);

    // Reset state
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h3);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_err", 32'(err_overflow), 32'h0);
    check("rst_stat", 32'(stat_xfer_cnt), 32'h0);

    // Latency: visible one cycle after the push, for one cycle only
    drive(2'b01, 16'h00A5, 0, 2'b11, 1'b0);
    drive(2'b00, 0, 0, 2'b11, 1'b0);
    drive(2'b00, 0, 0, 2'b11, 1'b0);

    // Full and overflow on ch1
    for (int i = 1; i <= 5; i++) drive(2'b10, 0, DW'(i), 2'b01, 1'b0);
    #1;
    check("ovf_in_ready1", 32'(in_ready[1]), 32'h0);
    check("ovf_sticky", 32'(err_overflow), 32'h1);
    for (int i = 0; i < 6; i++) drive(2'b00, 0, 0, 2'b11, 1'b0);
    check("ovf_still_set", 32'(err_overflow), 32'h1);

    // Fairness
    for (int i = 0; i < 3; i++) drive(2'b11, DW'(10 + i), DW'(20 + i), 2'b00, 1'b0);
    for (int i = 0; i < 7; i++) drive(2'b00, 0, 0, 2'b11, 1'b0);

    // No head-of-line blocking
    for (int i = 0; i < 3; i++) drive(2'b11, DW'(30 + i), DW'(40 + i), 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) drive(2'b00, 0, 0, 2'b10, 1'b0);
    for (int i = 0; i < 4; i++) drive(2'b00, 0, 0, 2'b01, 1'b0);

    // Reset mid-operation with buffered entries and counted transfers
    drive(2'b01, 16'h0051, 0, 2'b00, 1'b0);
    drive(2'b01, 16'h0052, 0, 2'b00, 1'b0);
    drive(2'b00, 0, 0, 2'b01, 1'b0);
    drive(2'b00, 0, 0, 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) drive(2'b01, DW'(16'h60 + i), 0, 2'b00, 1'b0);
    drive(2'b11, 16'h0070, 16'h0071, 2'b11, 1'b1);
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'h3);
    check("midrst_stat0", 32'(stat_xfer_cnt[0]), 32'h0);
    drive(2'b11, 16'h0080, 16'h0081, 2'b00, 1'b0);
    drive(2'b00, 0, 0, 2'b11, 1'b0);
    drive(2'b00, 0, 0, 2'b11, 1'b0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      drive(2'($urandom), DW'($urandom), DW'($urandom), 2'($urandom),
            1'($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
